// File: rtl/asynchronous_fifo_write_controller.sv
// -----------------------------------------------------------------------------
// asynchronous_fifo_write_controller
//
// Write-clock half of a dual-clock FIFO. Accepts producer words, drives the
// write port of a dual-port memory, keeps the binary and Gray write pointers,
// brings the read controller's Gray pointer into this domain and derives
// full / almost_full / fill_level / overflow status from it.
//
// Pointers are $clog2(DATA_DEPTH) bits wide with no extra wrap bit: equal
// pointers mean empty, so the writer stops one slot short of the reader and
// the usable capacity is DATA_DEPTH-1.
//
// Handshake: the producer raises write_enable with write_data; the word is
// taken on the rising clock edge only if full is low in that same cycle.
// A write_enable seen while full is high is dropped and sets the sticky
// overflow flag. There is no backpressure other than full.
//
// Ports
//   clock                 in   write-domain clock
//   reset_n               in   asynchronous active-low reset
//   write_enable          in   producer requests a write this cycle
//   write_data            in   word to write
//   read_pointer_gray     in   Gray read pointer from the read clock domain
//   clear_overflow        in   synchronous clear of the sticky overflow flag
//   memory_write_enable   out  registered memory write strobe
//   memory_write_address  out  registered memory write address
//   memory_write_data     out  registered memory write data
//   write_pointer_gray    out  registered Gray write pointer for the reader
//   full                  out  no write is accepted this cycle
//   almost_full           out  fill_level >= ALMOST_FULL_THRESHOLD
//   fill_level            out  write-side occupancy estimate (pessimistic)
//   overflow              out  sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module asynchronous_fifo_write_controller #(
    parameter int DATA_WIDTH            = 16,
    parameter int DATA_DEPTH            = 4096,
    parameter int ALMOST_FULL_THRESHOLD = DATA_DEPTH - 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          write_enable,
    input  logic [DATA_WIDTH-1:0]         write_data,
    input  logic [$clog2(DATA_DEPTH)-1:0] read_pointer_gray,
    input  logic                          clear_overflow,
    output logic                          memory_write_enable,
    output logic [$clog2(DATA_DEPTH)-1:0] memory_write_address,
    output logic [DATA_WIDTH-1:0]         memory_write_data,
    output logic [$clog2(DATA_DEPTH)-1:0] write_pointer_gray,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(DATA_DEPTH)-1:0] fill_level,
    output logic                          overflow
);

    localparam int P = $clog2(DATA_DEPTH);
    localparam logic [P-1:0] POINTER_ONE        = P'(1);
    localparam logic [P-1:0] ALMOST_FULL_LEVEL  = P'(ALMOST_FULL_THRESHOLD);

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above its position.
    function automatic logic [P-1:0] gray_to_binary(input logic [P-1:0] gray);
        logic [P-1:0] binary;
        binary[P-1] = gray[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            binary[i] = binary[i+1] ^ gray[i];
        end
        return binary;
    endfunction

    function automatic logic [P-1:0] binary_to_gray(input logic [P-1:0] binary);
        return binary ^ (binary >> 1);
    endfunction

    logic [P-1:0] write_pointer;
    logic [P-1:0] read_pointer_sync_0;
    logic [P-1:0] read_pointer_sync_1;

    logic [P-1:0] read_pointer_binary;
    logic         accept;
    logic [P-1:0] next_write_pointer;
    logic         full_next;
    logic [P-1:0] fill_level_next;
    logic         almost_full_next;
    logic         overflow_set;

    // Two-flop synchronizer for the reader's Gray pointer. Only one bit
    // changes per read-side increment, so a sample caught mid-transition is
    // either the old or the new pointer, never a torn value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer_sync_0 <= '0;
            read_pointer_sync_1 <= '0;
        end else begin
            read_pointer_sync_0 <= read_pointer_gray;
            read_pointer_sync_1 <= read_pointer_sync_0;
        end
    end

    // Status is computed from the post-edge write pointer and the currently
    // synchronized read pointer. Because the read pointer is stale by a few
    // write clocks, occupancy can only be overstated, which keeps full safe.
    always_comb begin
        read_pointer_binary = gray_to_binary(read_pointer_sync_1);
        accept              = write_enable && !full;
        next_write_pointer  = write_pointer;
        if (accept) begin
            next_write_pointer = write_pointer + POINTER_ONE;
        end
        full_next        = (next_write_pointer + POINTER_ONE) == read_pointer_binary;
        fill_level_next  = next_write_pointer - read_pointer_binary;
        almost_full_next = fill_level_next >= ALMOST_FULL_LEVEL;
        overflow_set     = write_enable && full;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_pointer        <= '0;
            write_pointer_gray   <= '0;
            memory_write_enable  <= 1'b0;
            memory_write_address <= '0;
            memory_write_data    <= '0;
            full                 <= 1'b0;
            almost_full          <= 1'b0;
            fill_level           <= '0;
            overflow             <= 1'b0;
        end else begin
            memory_write_enable <= accept;
            if (accept) begin
                memory_write_address <= write_pointer;
                memory_write_data    <= write_data;
            end
            write_pointer <= next_write_pointer;

            // Published from the pre-edge pointer: the reader learns of an
            // entry one edge after its memory strobe, i.e. after the write
            // into memory has landed.
            write_pointer_gray <= binary_to_gray(write_pointer);

            full        <= full_next;
            fill_level  <= fill_level_next;
            almost_full <= almost_full_next;

            // A rejected write wins over a simultaneous clear.
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_asynchronous_fifo_write_controller.sv
// -----------------------------------------------------------------------------
// Testbench for asynchronous_fifo_write_controller (DATA_DEPTH=8, threshold 4).
// Directed vector tables plus hand-written corner sequences, and a randomized
// phase checked against an occupancy-based reference model and a scoreboard
// of expected memory writes.
// -----------------------------------------------------------------------------
module tb_asynchronous_fifo_write_controller;

  localparam int W = 16;
  localparam int D = 8;
  localparam int T = 4;
  localparam int P = $clog2(D);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT connections ----------------
  logic         we_r = 1'b0;
  logic [W-1:0] data_r = '0;
  logic [P-1:0] rp_bin = '0;
  logic [P-1:0] rp_gray;
  logic         clr_r = 1'b0;

  logic         memory_write_enable;
  logic [P-1:0] memory_write_address;
  logic [W-1:0] memory_write_data;
  logic [P-1:0] write_pointer_gray;
  logic         full;
  logic         almost_full;
  logic [P-1:0] fill_level;
  logic         overflow;

  assign rp_gray = rp_bin ^ (rp_bin >> 1);

  asynchronous_fifo_write_controller #(
    .DATA_WIDTH(W),
    .DATA_DEPTH(D),
    .ALMOST_FULL_THRESHOLD(T)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .write_enable(we_r),
    .write_data(data_r),
    .read_pointer_gray(rp_gray),
    .clear_overflow(clr_r),
    .memory_write_enable(memory_write_enable),
    .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data),
    .write_pointer_gray(write_pointer_gray),
    .full(full),
    .almost_full(almost_full),
    .fill_level(fill_level),
    .overflow(overflow)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the writer as an integer slot count and the reader as a queue of
  // driven binary pointers; status follows from occupancy arithmetic.
  int m_wp = 0;
  int m_mwe = 0, m_addr = 0, m_data = 0, m_wpg = 0;
  int m_full = 0, m_af = 0, m_fill = 0, m_ovf = 0;
  int rp_hist[$] = '{0, 0};
  logic [P+W-1:0] exp_q[$];

  task automatic model_reset();
    m_wp = 0; m_mwe = 0; m_addr = 0; m_data = 0; m_wpg = 0;
    m_full = 0; m_af = 0; m_fill = 0; m_ovf = 0;
    rp_hist.delete();
    rp_hist.push_back(0);
    rp_hist.push_back(0);
    exp_q.delete();
  endtask

  task automatic model_step();
    int rs;
    bit acc;
    // The reader's pointer seen by the status logic is the one driven two
    // edges ago.
    rs = rp_hist[0];
    rp_hist.pop_front();
    rp_hist.push_back(int'(rp_bin));
    acc = we_r && (m_full == 0);
    if (we_r && (m_full != 0)) m_ovf = 1;
    else if (clr_r) m_ovf = 0;
    m_wpg = m_wp ^ (m_wp >> 1);
    m_mwe = acc ? 1 : 0;
    if (acc) begin
      m_addr = m_wp;
      m_data = int'(data_r);
      exp_q.push_back({P'(m_wp), data_r});
      m_wp = (m_wp + 1) % D;
    end
    m_fill = (m_wp - rs + D) % D;
    m_full = (m_fill == D - 1) ? 1 : 0;
    m_af = (m_fill >= T) ? 1 : 0;
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor: model compare, scoreboard, Gray steps ----------
  logic [P-1:0] prev_wpg = '0;
  bit prev_valid = 0;

  initial begin
    forever begin
      @(negedge reset_n);
      prev_valid = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("model.mwe", int'(memory_write_enable), m_mwe);
      chk("model.addr", int'(memory_write_address), m_addr);
      chk("model.data", int'(memory_write_data), m_data);
      chk("model.wpg", int'(write_pointer_gray), m_wpg);
      chk("model.full", int'(full), m_full);
      chk("model.almost_full", int'(almost_full), m_af);
      chk("model.fill", int'(fill_level), m_fill);
      chk("model.overflow", int'(overflow), m_ovf);
      if (memory_write_enable) begin
        if (exp_q.size() == 0) begin
          chk("sb.unexpected_write", 1, 0);
        end else begin
          chk("sb.word", int'({memory_write_address, memory_write_data}), int'(exp_q.pop_front()));
        end
      end
      if (prev_valid && (write_pointer_gray != prev_wpg)) begin
        chk("gray.one_bit_step", $countones(write_pointer_gray ^ prev_wpg), 1);
      end
      prev_wpg = write_pointer_gray;
      prev_valid = reset_n;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives inputs, lets one rising edge pass and
  // returns at the next falling edge where outputs are stable.
  task automatic drive_cycle(input int we, input int d, input int rp, input int clr);
    we_r = (we != 0);
    data_r = W'(d);
    rp_bin = P'(rp);
    clr_r = (clr != 0);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    we_r = 1'b0;
    clr_r = 1'b0;
    rp_bin = '0;
    data_r = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mwe"}, int'(memory_write_enable), 0);
    chk({tag, ".addr"}, int'(memory_write_address), 0);
    chk({tag, ".data"}, int'(memory_write_data), 0);
    chk({tag, ".wpg"}, int'(write_pointer_gray), 0);
    chk({tag, ".full"}, int'(full), 0);
    chk({tag, ".almost_full"}, int'(almost_full), 0);
    chk({tag, ".fill"}, int'(fill_level), 0);
    chk({tag, ".overflow"}, int'(overflow), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int we; int data; int rp; int clr;
    int mwe; int addr; int wdata; int wpg; int full; int af; int fill; int ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int we, input int data, input int rp, input int clr,
                         input int mwe, input int addr, input int wdata, input int wpg,
                         input int fl, input int af, input int fill, input int ovf);
    vec_t v;
    v.we = we; v.data = data; v.rp = rp; v.clr = clr;
    v.mwe = mwe; v.addr = addr; v.wdata = wdata; v.wpg = wpg;
    v.full = fl; v.af = af; v.fill = fill; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].we, vecs[i].data, vecs[i].rp, vecs[i].clr);
      chk($sformatf("%s[%0d].mwe", tag, i), int'(memory_write_enable), vecs[i].mwe);
      chk($sformatf("%s[%0d].addr", tag, i), int'(memory_write_address), vecs[i].addr);
      chk($sformatf("%s[%0d].data", tag, i), int'(memory_write_data), vecs[i].wdata);
      chk($sformatf("%s[%0d].wpg", tag, i), int'(write_pointer_gray), vecs[i].wpg);
      chk($sformatf("%s[%0d].full", tag, i), int'(full), vecs[i].full);
      chk($sformatf("%s[%0d].almost_full", tag, i), int'(almost_full), vecs[i].af);
      chk($sformatf("%s[%0d].fill", tag, i), int'(fill_level), vecs[i].fill);
      chk($sformatf("%s[%0d].overflow", tag, i), int'(overflow), vecs[i].ovf);
    end
    vecs.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset state, checked without any clock edge.
    #1 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Fill with read pointer 0, drain one slot while full, overflow clear.
    //       we data  rp clr | mwe addr wdata wpg full af fill ovf
    add_vec(1, 'h11, 0, 0,   1, 0, 'h11, 0, 0, 0, 1, 0);
    add_vec(1, 'h12, 0, 0,   1, 1, 'h12, 1, 0, 0, 2, 0);
    add_vec(1, 'h13, 0, 0,   1, 2, 'h13, 3, 0, 0, 3, 0);
    add_vec(1, 'h14, 0, 0,   1, 3, 'h14, 2, 0, 1, 4, 0);
    add_vec(1, 'h15, 0, 0,   1, 4, 'h15, 6, 0, 1, 5, 0);
    add_vec(1, 'h16, 0, 0,   1, 5, 'h16, 7, 0, 1, 6, 0);
    add_vec(1, 'h17, 0, 0,   1, 6, 'h17, 5, 1, 1, 7, 0);
    add_vec(1, 'h18, 0, 0,   0, 6, 'h17, 4, 1, 1, 7, 1);
    add_vec(1, 'h19, 0, 0,   0, 6, 'h17, 4, 1, 1, 7, 1);
    add_vec(1, 'h1A, 0, 0,   0, 6, 'h17, 4, 1, 1, 7, 1);
    add_vec(0, 0,    1, 0,   0, 6, 'h17, 4, 1, 1, 7, 1);
    add_vec(0, 0,    1, 0,   0, 6, 'h17, 4, 1, 1, 7, 1);
    add_vec(0, 0,    1, 0,   0, 6, 'h17, 4, 0, 1, 6, 1);
    add_vec(1, 'h1B, 1, 0,   1, 7, 'h1B, 4, 1, 1, 7, 1);
    add_vec(0, 0,    1, 0,   0, 7, 'h1B, 0, 1, 1, 7, 1);
    add_vec(0, 0,    1, 1,   0, 7, 'h1B, 0, 1, 1, 7, 0);
    add_vec(1, 'h1C, 1, 1,   0, 7, 'h1B, 0, 1, 1, 7, 1);
    add_vec(0, 0,    1, 1,   0, 7, 'h1B, 0, 1, 1, 7, 0);
    run_vecs("fill");

    // Gray read-pointer decode: writer at 6, reader jumps to 4 then 5.
    do_reset();
    add_vec(1, 'h21, 0, 0,   1, 0, 'h21, 0, 0, 0, 1, 0);
    add_vec(1, 'h22, 0, 0,   1, 1, 'h22, 1, 0, 0, 2, 0);
    add_vec(1, 'h23, 0, 0,   1, 2, 'h23, 3, 0, 0, 3, 0);
    add_vec(1, 'h24, 0, 0,   1, 3, 'h24, 2, 0, 1, 4, 0);
    add_vec(1, 'h25, 0, 0,   1, 4, 'h25, 6, 0, 1, 5, 0);
    add_vec(1, 'h26, 0, 0,   1, 5, 'h26, 7, 0, 1, 6, 0);
    add_vec(0, 0,    4, 0,   0, 5, 'h26, 5, 0, 1, 6, 0);
    add_vec(0, 0,    4, 0,   0, 5, 'h26, 5, 0, 1, 6, 0);
    add_vec(0, 0,    4, 0,   0, 5, 'h26, 5, 0, 0, 2, 0);
    add_vec(0, 0,    5, 0,   0, 5, 'h26, 5, 0, 0, 2, 0);
    add_vec(0, 0,    5, 0,   0, 5, 'h26, 5, 0, 0, 2, 0);
    add_vec(0, 0,    5, 0,   0, 5, 'h26, 5, 0, 0, 1, 0);
    run_vecs("gray");

    // Wrap: reader keeps pace, 20 back-to-back writes with no bubble.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1, 'h100 + i, i % D, 0);
      chk($sformatf("wrap[%0d].mwe", i), int'(memory_write_enable), 1);
      chk($sformatf("wrap[%0d].addr", i), int'(memory_write_address), i % D);
      chk($sformatf("wrap[%0d].data", i), int'(memory_write_data), 'h100 + i);
    end

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1, 'h31 + i, 0, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    drive_cycle(1, 'h41, 0, 0);
    chk("post_reset.mwe", int'(memory_write_enable), 1);
    chk("post_reset.addr", int'(memory_write_address), 0);
    chk("post_reset.data", int'(memory_write_data), 'h41);

    // Randomized traffic: fast reader, then slow reader to force full.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int read_pct;
      int next_rp;
      read_pct = (i < 200) ? 80 : 30;
      next_rp = int'(rp_bin);
      if ((next_rp != m_wp) && ($urandom_range(0, 99) < read_pct)) next_rp = (next_rp + 1) % D;
      drive_cycle(($urandom_range(0, 99) < 70) ? 1 : 0, int'($urandom_range(0, 16'hFFFF)),
                  next_rp, ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
